// File: rtl/lvds_rx_frame_ctrl.sv
// Frame controller for the LVDS receive buffer: waits for a captured frame, streams
// every buffer word out over valid/ready with a running checksum, then clears the receiver.
module lvds_rx_frame_ctrl #(
    parameter int WORDS    = 512,
    parameter int ADDR_W   = 9,
    parameter int CLR_HOLD = 4,
    parameter int TIMEOUT  = 65535
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ARM,
    input  logic              ABORT,
    input  logic [7:0]        LVDS_EU_STATE,
    output logic [ADDR_W-1:0] EU_LVDS_BUF_ADDR,
    input  logic [31:0]       EU_LVDS_BUF_DATA,
    output logic              LVDS_STATE_CLEAR_CS,
    output logic              LVDS_STATE_CLEAR,
    output logic [31:0]       OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_LAST,
    output logic [31:0]       CHECKSUM,
    output logic              FRAME_DONE,
    output logic [15:0]       FRAME_CNT,
    output logic              BUSY,
    output logic              ERR_TIMEOUT
);

    // state      | meaning
    // IDLE       | waiting for ARM
    // WAIT_FRAME | capture armed, waiting for receiver state 2 (frame over)
    // FETCH      | buffer address presented
    // LATCH      | buffer data registered into OUT_DATA
    // SEND       | OUT_VALID held until the sink accepts
    // CLEAR      | receiver clear lines held until it reports idle
    // DONE       | one-cycle frame-complete pulse
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FRAME, S_FETCH, S_LATCH, S_SEND, S_CLEAR, S_DONE
    } state_t;

    localparam int TMO_W  = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
    localparam int HOLD_W = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CLR_HOLD - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t             state, state_nx;
    logic [7:0]         sync1, sync2, sync3, st_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [ADDR_W-1:0]  addr;
    logic               arm_go, hs, tmo_zero, hold_zero, frame_rdy, rx_idle;
    logic               clear_ok, tmo_fire, clr_entry;

    assign arm_go    = (state == S_IDLE) && ARM && !ABORT;
    assign hs        = OUT_VALID && OUT_READY;
    assign tmo_zero  = (tmo_cnt == '0);
    assign hold_zero = (hold_cnt == '0);
    assign frame_rdy = (st_q == 8'd2);
    assign rx_idle   = (st_q == 8'd0);
    assign clear_ok  = hold_zero && rx_idle;
    assign tmo_fire  = !ABORT && tmo_zero &&
                       (((state == S_WAIT_FRAME) && !frame_rdy) ||
                        ((state == S_CLEAR) && !clear_ok));
    assign clr_entry = (state_nx == S_CLEAR) && (state != S_CLEAR);

    assign EU_LVDS_BUF_ADDR    = addr;
    assign BUSY                = (state != S_IDLE);
    assign LVDS_STATE_CLEAR_CS = (state == S_CLEAR);
    assign LVDS_STATE_CLEAR    = (state == S_CLEAR);
    assign FRAME_DONE          = (state == S_DONE) && !ABORT;

    always_ff @(posedge CLK) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:       if (ARM) state_nx = S_WAIT_FRAME;
            S_WAIT_FRAME: begin
                if (frame_rdy)     state_nx = S_FETCH;
                else if (tmo_zero) state_nx = S_CLEAR;
            end
            S_FETCH:      state_nx = S_LATCH;
            S_LATCH:      state_nx = S_SEND;
            S_SEND:       if (hs) state_nx = OUT_LAST ? S_CLEAR : S_FETCH;
            S_CLEAR: begin
                if (clear_ok)      state_nx = ERR_TIMEOUT ? S_IDLE : S_DONE;
                else if (tmo_zero) state_nx = S_IDLE;
            end
            S_DONE:       state_nx = S_IDLE;
            default:      state_nx = S_IDLE;
        endcase
        if (ABORT) state_nx = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sync1       <= '0;
            sync2       <= '0;
            sync3       <= '0;
            st_q        <= '0;
            tmo_cnt     <= '0;
            hold_cnt    <= '0;
            addr        <= '0;
            OUT_DATA    <= '0;
            OUT_VALID   <= 1'b0;
            OUT_LAST    <= 1'b0;
            CHECKSUM    <= '0;
            FRAME_CNT   <= '0;
            ERR_TIMEOUT <= 1'b0;
        end else begin
            // st_q only follows a value seen on two consecutive samples, so a
            // multi-bit code caught mid-transition never reaches the FSM
            sync1 <= LVDS_EU_STATE;
            sync2 <= sync1;
            sync3 <= sync2;
            if (sync2 == sync3) st_q <= sync3;

            if (arm_go || clr_entry) tmo_cnt <= TMO_LOAD;
            else if (!tmo_zero)      tmo_cnt <= tmo_cnt - TMO_W'(1);

            if (clr_entry)       hold_cnt <= HOLD_LOAD;
            else if (!hold_zero) hold_cnt <= hold_cnt - HOLD_W'(1);

            if (arm_go) begin
                addr        <= '0;
                CHECKSUM    <= '0;
                ERR_TIMEOUT <= 1'b0;
            end
            if (tmo_fire) ERR_TIMEOUT <= 1'b1;

            if ((state == S_SEND) && (state_nx == S_FETCH)) addr <= addr + ADDR_W'(1);

            if ((state == S_LATCH) && !ABORT) begin
                OUT_DATA  <= EU_LVDS_BUF_DATA;
                OUT_VALID <= 1'b1;
                OUT_LAST  <= (addr == LAST_ADDR);
            end
            // a word accepted in the same cycle as ABORT still counts in the sum
            if ((state == S_SEND) && hs) begin
                OUT_VALID <= 1'b0;
                OUT_LAST  <= 1'b0;
                CHECKSUM  <= CHECKSUM + OUT_DATA;
            end
            if (ABORT) begin
                OUT_VALID <= 1'b0;
                OUT_LAST  <= 1'b0;
            end

            if (FRAME_DONE) FRAME_CNT <= FRAME_CNT + 16'd1;
        end
    end

endmodule

// File: tb/tb_lvds_rx_frame_ctrl.sv
// Bench for lvds_rx_frame_ctrl: directed frame scenarios plus a per-cycle model of
// the expected word stream, checksum and frame count.
module tb_lvds_rx_frame_ctrl;

    localparam int WORDS    = 512;
    localparam int ADDR_W   = 9;
    localparam int CLR_HOLD = 4;
    localparam int TIMEOUT  = 100;

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic              ARM = 1'b0;
    logic              ABORT = 1'b0;
    logic              OUT_READY = 1'b0;
    logic [7:0]        lvds_state = 8'd0;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_data = 32'd0;
    logic              clr_cs, clr;
    logic [31:0]       OUT_DATA, CHECKSUM;
    logic              OUT_VALID, OUT_LAST, FRAME_DONE, BUSY, ERR_TIMEOUT;
    logic [15:0]       FRAME_CNT;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;
    int words, lasts, dones, clr_cycles, valids, cyc, err_at;

    lvds_rx_frame_ctrl #(
        .WORDS(WORDS), .ADDR_W(ADDR_W), .CLR_HOLD(CLR_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .ARM(ARM), .ABORT(ABORT),
        .LVDS_EU_STATE(lvds_state),
        .EU_LVDS_BUF_ADDR(buf_addr), .EU_LVDS_BUF_DATA(buf_data),
        .LVDS_STATE_CLEAR_CS(clr_cs), .LVDS_STATE_CLEAR(clr),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_LAST(OUT_LAST), .CHECKSUM(CHECKSUM), .FRAME_DONE(FRAME_DONE),
        .FRAME_CNT(FRAME_CNT), .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // buffer RAM: word k holds k, read data one clock after the address
    always @(posedge CLK) buf_data <= 32'(buf_addr);

    function automatic logic [31:0] word_of(input int k);
        return 32'(k);
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // expected stream: k-th accepted word of a frame is word_of(k); sum and count follow
    task automatic monitor();
        int          m_idx = 0;
        logic [31:0] m_sum = 32'd0;
        logic [15:0] m_cnt = 16'd0;
        logic        p_stall = 1'b0;
        logic [31:0] p_data = 32'd0;
        logic        p_last = 1'b0;
        forever begin
            @(negedge CLK);
            chk32("checksum", CHECKSUM, m_sum);
            chk32("frame_cnt", 32'(FRAME_CNT), 32'(m_cnt));
            chk1("clear_pair", clr_cs, clr);
            if (p_stall) begin
                chk1("stall_valid", OUT_VALID, 1'b1);
                chk32("stall_data", OUT_DATA, p_data);
                chk1("stall_last", OUT_LAST, p_last);
            end
            if (OUT_VALID) begin
                chk1("word_in_range", m_idx < WORDS, 1'b1);
                chk32("word_data", OUT_DATA, word_of(m_idx));
                chk1("word_last", OUT_LAST, m_idx == WORDS - 1);
            end
            if (FRAME_DONE) chk32("done_all_words", 32'(m_idx), 32'(WORDS));
            if (!RSTn) begin
                m_idx = 0; m_sum = 32'd0; m_cnt = 16'd0; p_stall = 1'b0;
            end else begin
                if (OUT_VALID && OUT_READY) begin
                    m_sum += word_of(m_idx);
                    m_idx++;
                end
                if (FRAME_DONE) m_cnt++;
                if (ARM && !ABORT && !BUSY) begin
                    m_sum = 32'd0; m_idx = 0;
                end
                p_stall = OUT_VALID && !OUT_READY && !ABORT;
                p_data  = OUT_DATA;
                p_last  = OUT_LAST;
            end
        end
    endtask

    task automatic clr_stats();
        words = 0; lasts = 0; dones = 0; clr_cycles = 0; valids = 0; cyc = 0;
    endtask

    // one clock: pulses drop, ready policy applied, receiver answers clear with state 0
    task automatic step();
        @(posedge CLK); #1;
        ARM = 1'b0;
        ABORT = 1'b0;
        case (rdy_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = 1'($urandom_range(0, 1));
            default: OUT_READY = 1'b0;
        endcase
        if (OUT_VALID && OUT_READY) begin
            words++;
            if (OUT_LAST) lasts++;
        end
        if (OUT_VALID) valids++;
        if (FRAME_DONE) dones++;
        if (clr_cs) clr_cycles++;
        if (clr_cs && clr) lvds_state = 8'd0;
        cyc++;
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n = 0;
        while (BUSY && n < budget) begin
            step();
            n++;
        end
        chk1({name, "_budget"}, BUSY, 1'b0);
    endtask

    task automatic frame_checks(input string name, input logic [15:0] cnt);
        chk32({name, "_words"}, 32'(words), 32'(WORDS));
        chk32({name, "_lasts"}, 32'(lasts), 32'd1);
        chk32({name, "_dones"}, 32'(dones), 32'd1);
        chk32({name, "_checksum"}, CHECKSUM, 32'h0001_FF00);
        chk32({name, "_frame_cnt"}, 32'(FRAME_CNT), 32'(cnt));
        chk1({name, "_clear_hold"}, clr_cycles >= CLR_HOLD, 1'b1);
        chk1({name, "_err"}, ERR_TIMEOUT, 1'b0);
        chk1({name, "_clear_off"}, clr_cs, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk1("rst_busy", BUSY, 1'b0);
        chk1("rst_valid", OUT_VALID, 1'b0);
        chk1("rst_last", OUT_LAST, 1'b0);
        chk32("rst_data", OUT_DATA, 32'd0);
        chk32("rst_checksum", CHECKSUM, 32'd0);
        chk32("rst_frame_cnt", 32'(FRAME_CNT), 32'd0);
        chk32("rst_addr", 32'(buf_addr), 32'd0);
        chk1("rst_err", ERR_TIMEOUT, 1'b0);
        chk1("rst_clear", clr_cs, 1'b0);
        chk1("rst_done", FRAME_DONE, 1'b0);
        RSTn = 1'b1;
        fork
            monitor();
        join_none

        // full frame, sink always ready
        clr_stats();
        rdy_mode = 0;
        ARM = 1'b1; lvds_state = 8'd2;
        step();
        run_until_idle(3000, "frame1");
        frame_checks("frame1", 16'd1);

        // same frame, sink stalls at random
        clr_stats();
        rdy_mode = 1;
        ARM = 1'b1; lvds_state = 8'd2;
        step();
        run_until_idle(6000, "frame2");
        frame_checks("frame2", 16'd2);

        // receiver stuck capturing: timeout, clear, back to idle without a frame
        clr_stats();
        rdy_mode = 0;
        err_at = -1;
        ARM = 1'b1; lvds_state = 8'd1;
        step();
        while (BUSY && cyc < 400) begin
            step();
            if (ERR_TIMEOUT && err_at < 0) err_at = cyc;
        end
        chk1("tmo_budget", BUSY, 1'b0);
        chk1("tmo_err", ERR_TIMEOUT, 1'b1);
        chk1("tmo_window", (err_at >= TIMEOUT) && (err_at <= TIMEOUT + 8), 1'b1);
        chk32("tmo_dones", 32'(dones), 32'd0);
        chk32("tmo_valids", 32'(valids), 32'd0);
        chk1("tmo_clear_seen", clr_cycles >= CLR_HOLD, 1'b1);
        chk32("tmo_frame_cnt", 32'(FRAME_CNT), 32'd2);

        // next ARM clears the error; a one-cycle glitch to 2 must not start a read
        ARM = 1'b1; lvds_state = 8'd1;
        step();
        chk1("rearm_err_clear", ERR_TIMEOUT, 1'b0);
        chk1("rearm_busy", BUSY, 1'b1);
        clr_stats();
        repeat (5) step();
        lvds_state = 8'd2;
        step();
        lvds_state = 8'd1;
        repeat (12) step();
        chk32("glitch_no_fetch", 32'(valids), 32'd0);
        chk1("glitch_still_busy", BUSY, 1'b1);
        lvds_state = 8'd2;
        run_until_idle(3000, "frame3");
        frame_checks("frame3", 16'd3);

        // abort while word 100 is stalled
        clr_stats();
        rdy_mode = 0;
        ARM = 1'b1; lvds_state = 8'd2;
        step();
        while (words < 100 && cyc < 1000) step();
        rdy_mode = 2;
        repeat (6) step();
        chk1("abort_pre_valid", OUT_VALID, 1'b1);
        chk32("abort_pre_data", OUT_DATA, 32'd100);
        ABORT = 1'b1;
        step();
        chk1("abort_valid", OUT_VALID, 1'b0);
        chk1("abort_busy", BUSY, 1'b0);
        chk32("abort_checksum", CHECKSUM, 32'd4950);
        chk32("abort_frame_cnt", 32'(FRAME_CNT), 32'd3);
        chk32("abort_dones", 32'(dones), 32'd0);
        chk1("abort_clear_off", clr_cs, 1'b0);

        // ARM while busy is ignored; reset mid-SEND returns everything to zero
        clr_stats();
        rdy_mode = 0;
        ARM = 1'b1;
        step();
        while (words < 10 && cyc < 500) step();
        ARM = 1'b1;
        step();
        while (words < 20 && cyc < 500) step();
        rdy_mode = 2;
        repeat (6) step();
        chk32("busy_arm_checksum", CHECKSUM, 32'd190);
        chk1("busy_arm_valid", OUT_VALID, 1'b1);
        chk32("busy_arm_data", OUT_DATA, 32'd20);
        RSTn = 1'b0;
        step();
        RSTn = 1'b1;
        chk1("midrst_busy", BUSY, 1'b0);
        chk1("midrst_valid", OUT_VALID, 1'b0);
        chk1("midrst_last", OUT_LAST, 1'b0);
        chk32("midrst_data", OUT_DATA, 32'd0);
        chk32("midrst_checksum", CHECKSUM, 32'd0);
        chk32("midrst_frame_cnt", 32'(FRAME_CNT), 32'd0);
        chk32("midrst_addr", 32'(buf_addr), 32'd0);
        chk1("midrst_clear", clr_cs, 1'b0);

        ARM = 1'b1; ABORT = 1'b1;
        step();
        chk1("arm_abort_idle", BUSY, 1'b0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvds_rx_frame_ctrl.md
Name: lvds_rx_frame_ctrl

Overview:
- Sequences the LVDS receive buffer in the CLK domain: arms capture, waits for the receiver to report frame complete, reads all buffer words out over the buffer read port, and streams them to the EU over a valid/ready interface.
- Computes a running 32-bit additive checksum, then clears the receiver state so the next frame can be captured.
- Sits between the LVDS receiver (buffer read port, state/clear lines) and the EU bus logic.

Parameters:
- WORDS, 512, number of 32-bit words read per frame; 1..2^ADDR_W.
- ADDR_W, 9, buffer read address width.
- CLR_HOLD, 4, CLK cycles LVDS_STATE_CLEAR_CS/LVDS_STATE_CLEAR are held before the controller starts checking for state 0.
- TIMEOUT, 65535, max CLK cycles spent in WAIT_FRAME or CLEAR before the timeout error fires.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- ARM  in  1  1-cycle pulse: start one frame transaction; ignored unless BUSY=0.
- ABORT  in  1  level: return to IDLE next cycle from any state; wins over all other events.
- LVDS_EU_STATE  in  8  receiver status (LVDS_CLK domain): 0 idle, 1 receiving, 2 frame over.
- EU_LVDS_BUF_ADDR  out  ADDR_W  buffer read address.
- EU_LVDS_BUF_DATA  in  32  buffer read data; valid 1 CLK after the address is presented.
- LVDS_STATE_CLEAR_CS  out  1  clear chip-select to the receiver.
- LVDS_STATE_CLEAR  out  1  clear strobe to the receiver.
- OUT_DATA  out  32  streamed word.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  sink accepts when OUT_VALID & OUT_READY.
- OUT_LAST  out  1  high with the final word (index WORDS-1).
- CHECKSUM  out  32  sum mod 2^32 of all accepted words of the current/last frame.
- FRAME_DONE  out  1  1-cycle pulse when a frame completes cleanly.
- FRAME_CNT  out  16  count of completed frames; wraps 0xFFFF->0.
- BUSY  out  1  high in any state other than IDLE.
- ERR_TIMEOUT  out  1  sticky; set on timeout; cleared by the next ARM or by reset.

Behaviour:
- Reset (RSTn=0 at a CLK edge):
  - All outputs go to 0 and state goes to IDLE.
  - Synchronizer flops, address, checksum and counters are cleared.
- State synchronization:
  - LVDS_EU_STATE passes through 2 flops.
  - st_q updates only when two consecutive synchronizer outputs are equal, which filters multi-bit skew.
  - All decisions use st_q. Worst case 3-4 cycles behind the receiver.
- States: IDLE, WAIT_FRAME, FETCH, LATCH, SEND, CLEAR, DONE.
- IDLE:
  - ARM -> WAIT_FRAME.
  - On entry from ARM: address=0, CHECKSUM=0, ERR_TIMEOUT=0, timeout counter=0.
- WAIT_FRAME:
  - st_q==2 -> FETCH.
  - Timeout counter reaching TIMEOUT -> set ERR_TIMEOUT, go to CLEAR.
- FETCH: drive EU_LVDS_BUF_ADDR=addr -> LATCH.
- LATCH:
  - Register EU_LVDS_BUF_DATA into OUT_DATA; set OUT_VALID=1.
  - Set OUT_LAST = (addr==WORDS-1) -> SEND.
- SEND:
  - Hold OUT_DATA/OUT_VALID/OUT_LAST stable until OUT_READY.
  - On handshake: OUT_VALID=0, CHECKSUM += OUT_DATA.
  - If OUT_LAST -> CLEAR; else addr+1 -> FETCH.
  - Minimum 3 cycles per word.
- EU_LVDS_BUF_ADDR holds its value outside FETCH. The address never exceeds WORDS-1; no wrap.
- CLEAR:
  - Assert LVDS_STATE_CLEAR_CS=1 and LVDS_STATE_CLEAR=1 for at least CLR_HOLD cycles.
  - Then keep both asserted until st_q==0.
  - Timeout counter restarts on entry; reaching TIMEOUT sets ERR_TIMEOUT and forces exit.
  - Exit goes to DONE if no error, else to IDLE. Both clear outputs deassert on exit.
- DONE:
  - FRAME_DONE=1 for this cycle, FRAME_CNT+1 -> IDLE.
  - CHECKSUM holds until the next ARM.
- ABORT in any state:
  - Next state IDLE; OUT_VALID, OUT_LAST and clear outputs drop.
  - No FRAME_DONE; CHECKSUM and FRAME_CNT unchanged.
  - ABORT in the same cycle as an OUT handshake: the word counts as accepted in CHECKSUM; the frame still aborts.
- ARM while BUSY: ignored.
- ARM together with ABORT in IDLE: stays IDLE.
- st_q==1 in WAIT_FRAME: keep waiting (capture in progress).
- Reset mid-frame: immediate return to the reset values on that edge; the receiver is not cleared. The next ARM sees st_q==2 and reads stale data; this is intended.

Test Plan:
- Drive LVDS_EU_STATE=2 after ARM; buffer word k = k; OUT_READY=1 -> 512 words 0..511 in order, OUT_LAST only on word 511, CHECKSUM=0x0001FF00, FRAME_DONE pulse, FRAME_CNT=1, clear lines held ≥4 cycles until state returns to 0.
- Same frame with OUT_READY toggled randomly (50%) -> OUT_DATA/OUT_LAST stable while stalled; identical word sequence and CHECKSUM.
- ARM, keep LVDS_EU_STATE=1 beyond TIMEOUT (set 100) -> ERR_TIMEOUT=1, clear asserted, then IDLE; no FRAME_DONE; next ARM clears ERR_TIMEOUT.
- Glitch LVDS_EU_STATE to 2 for one CLK during WAIT_FRAME -> no FETCH; a stable 2 for ≥3 cycles starts the read.
- ABORT during word 100 stall -> IDLE next cycle, OUT_VALID=0, CHECKSUM=sum of words 0..99, FRAME_CNT unchanged.
- Assert RSTn=0 for 1 cycle mid-SEND -> all outputs 0 next cycle, BUSY=0; ARM while BUSY is ignored.
